lcd_ctrl: RTL and testbench

//   Sequencer for the character-LCD port of the single-cycle core's IO block. Accepts one

---
 rtl/lcd_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// lcd_ctrl -- character-LCD write sequencer for the core's IO block.
//
// Accepts one command/data byte per req_vld/req_rdy handshake and drives the
// HD44780-style pins: RS/DATA setup, E pulse, RS/DATA hold, then a post-write
// wait (long wait for clear/home commands 8'h01..8'h03 with rs=0).
//
// Handshake: a request transfers on a rising clk edge where req_vld && req_rdy
// (only possible in IDLE). req_rs/req_data are captured on that edge and
// req_rdy drops after it. req_rdy is a register, so there is no combinational
// path from req_vld to req_rdy. Requests while busy are ignored, not queued.
//
// Optional feature: define LCD_INIT_EN to build the power-on delay and the
// 4-command init sequence (38, 0C, 01, 06); req_rdy stays low until it ends.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_vld/req_rdy request handshake; req_rs (0=cmd,1=data), req_data byte
//   busy            inverse of req_rdy
//   lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data   LCD pins
//   io_lcd          packed {lcd_on, 20'b0, en, rs, rw, data}
//   fsm_state       current FSM state, for observation only
module lcd_ctrl #(
    parameter int SETUP_CYC     = 4,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 4,
    parameter int CMD_WAIT_CYC  = 2000,
    parameter int CLR_WAIT_CYC  = 80000,
    parameter int INIT_WAIT_CYC = 800000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_rs,
    input  logic [7:0]  req_data,
    output logic        busy,
    output logic        lcd_on,
    output logic        lcd_en,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data,
    output logic [31:0] io_lcd,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_INIT_WAIT = 3'd0,
        S_IDLE      = 3'd1,
        S_SETUP     = 3'd2,
        S_PULSE     = 3'd3,
        S_HOLD      = 3'd4,
        S_WAIT      = 3'd5
    } state_t;

    // One shared down-counter, wide enough for the largest load value.
    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_B   = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
    localparam int MAX_C   = (CLR_WAIT_CYC > INIT_WAIT_CYC) ? CLR_WAIT_CYC : INIT_WAIT_CYC;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CW      = $clog2(MAX_CYC + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_clear;

    // Clear/home commands need the long post-write wait.
    assign is_clear = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02 ||
                                  lcd_data == 8'h03);

    assign lcd_on    = 1'b1;
    assign lcd_rw    = 1'b0;
    assign io_lcd    = {lcd_on, 20'b0, lcd_en, lcd_rs, lcd_rw, lcd_data};
    assign fsm_state = state;

`ifdef LCD_INIT_EN
    logic [1:0] init_idx;
    logic       init_busy;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
`ifdef LCD_INIT_EN
            state     <= S_INIT_WAIT;
            cnt       <= CW'(INIT_WAIT_CYC - 1);
            req_rdy   <= 1'b0;
            busy      <= 1'b1;
            init_idx  <= 2'd0;
            init_busy <= 1'b1;
`else
            state   <= S_IDLE;
            cnt     <= '0;
            req_rdy <= 1'b1;
            busy    <= 1'b0;
`endif
        end else begin
            case (state)
`ifdef LCD_INIT_EN
                S_INIT_WAIT: begin
                    if (cnt == '0) begin
                        lcd_rs   <= 1'b0;
                        lcd_data <= init_byte(2'd0);
                        cnt      <= CW'(SETUP_CYC - 1);
                        state    <= S_SETUP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                S_IDLE: begin
                    if (req_vld && req_rdy) begin
                        lcd_rs   <= req_rs;
                        lcd_data <= req_data;
                        req_rdy  <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= CW'(SETUP_CYC - 1);
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        lcd_en <= 1'b1;
                        cnt    <= CW'(PULSE_CYC - 1);
                        state  <= S_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        lcd_en <= 1'b0;
                        cnt    <= CW'(HOLD_CYC - 1);
                        state  <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= is_clear ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
`ifdef LCD_INIT_EN
                        if (init_busy && init_idx != 2'd3) begin
                            // Next init command goes straight to SETUP.
                            init_idx <= init_idx + 2'd1;
                            lcd_rs   <= 1'b0;
                            lcd_data <= init_byte(init_idx + 2'd1);
                            cnt      <= CW'(SETUP_CYC - 1);
                            state    <= S_SETUP;
                        end else begin
                            init_busy <= 1'b0;
                            req_rdy   <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
`else
                        req_rdy <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    lcd_en  <= 1'b0;
                    req_rdy <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with small timing parameters:
// SETUP=2 PULSE=3 HOLD=2 CMD_WAIT=5 CLR_WAIT=20 INIT_WAIT=10.
// A normal write takes 12 cycles, a clear/home write 27 cycles.
module tb_lcd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0;
    logic        req_rs = 1'b0;
    logic [7:0]  req_data = 8'h00;
    logic        req_rdy, busy, lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0]  lcd_data;
    logic [31:0] io_lcd;
    logic [2:0]  fsm_state;

    lcd_ctrl #(
        .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2),
        .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(20), .INIT_WAIT_CYC(10)
    ) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_rs(req_rs), .req_data(req_data), .busy(busy), .lcd_on(lcd_on),
        .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
        .io_lcd(io_lcd), .fsm_state(fsm_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- check / scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_q[$];
    int         exp_cyc[$];
    logic       sb_on = 1'b0;
    int         pulse_cnt = 0;
    logic       en_prev = 1'b0;

    // Every rising E pulse is counted; when the scoreboard is armed its byte
    // and arrival cycle are compared with the next expected entry.
    always @(negedge clk) begin
        if (lcd_en && !en_prev) begin
            pulse_cnt++;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pulse", {24'h0, lcd_data}, 32'hFFFF_FFFF);
                end else begin
                    check("sb_data", {24'h0, lcd_data}, {24'h0, exp_q.pop_front()});
                    if (exp_cyc.size() != 0)
                        check("sb_cycle", cyc, exp_cyc.pop_front());
                end
            end
        end
        en_prev = lcd_en;
    end

    // ---------------- driver ----------------
    // Presents one request, then samples every negedge until req_rdy returns.
    // lat = cycles from the accept edge to req_rdy high; mask bit k = lcd_en
    // k cycles after the accept edge.
    task automatic write_measure(input logic rs, input logic [7:0] d,
                                 output int lat, output logic [31:0] mask,
                                 output logic ok, output logic [31:0] io_pulse,
                                 output logic [31:0] io_setup);
        @(negedge clk);
        req_vld  = 1'b1;
        req_rs   = rs;
        req_data = d;
        @(negedge clk);
        req_vld  = 1'b0;
        lat      = 0;
        mask     = '0;
        ok       = 1'b1;
        io_pulse = '0;
        io_setup = '0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 32) mask[k] = lcd_en;
            if (lcd_data !== d || lcd_rs !== rs) ok = 1'b0;
            if (k == 0) io_setup = io_lcd;
            if (lcd_en && io_pulse == 32'h0) io_pulse = io_lcd;
            lat = k;
            if (req_rdy) break;
        end
    endtask

    // Directed command vectors: {rs, byte, expected latency}
    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    int          lat, base;
    logic [31:0] mask, io_p, io_s;
    logic        ok, seen;

    initial begin
        vecs[0] = '{1'b0, 8'h01, 27};
        vecs[1] = '{1'b0, 8'h02, 27};
        vecs[2] = '{1'b0, 8'h03, 27};
        vecs[3] = '{1'b0, 8'h00, 12};
        vecs[4] = '{1'b0, 8'h04, 12};
        vecs[5] = '{1'b0, 8'h80, 12};
        vecs[6] = '{1'b1, 8'h01, 12};

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) @(negedge clk);
`ifdef LCD_INIT_EN
        check("rst_rdy", {31'h0, req_rdy}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h1);
`else
        check("rst_rdy", {31'h0, req_rdy}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
`endif
        check("rst_io", io_lcd, 32'h8000_0000);
        check("rst_en", {31'h0, lcd_en}, 32'h0);
        check("rst_rw", {31'h0, lcd_rw}, 32'h0);
        check("rst_on", {31'h0, lcd_on}, 32'h1);
        rst = 1'b0;

`ifdef LCD_INIT_EN
        // ---- init sequence: setup entries at +10, +22, +34, +61 ----
        base = cyc;
        exp_q.push_back(8'h38); exp_cyc.push_back(base + 12);
        exp_q.push_back(8'h0C); exp_cyc.push_back(base + 24);
        exp_q.push_back(8'h01); exp_cyc.push_back(base + 36);
        exp_q.push_back(8'h06); exp_cyc.push_back(base + 63);
        sb_on = 1'b1;
        while (cyc < base + 72) @(negedge clk);
        check("init_rdy_low", {31'h0, req_rdy}, 32'h0);
        @(negedge clk);
        check("init_rdy_high", {31'h0, req_rdy}, 32'h1);
        check("init_sb_left", exp_q.size(), 32'h0);
        sb_on = 1'b0;
`endif

        // ---- data write 'A' ----
        write_measure(1'b1, 8'h41, lat, mask, ok, io_p, io_s);
        check("data_lat", lat, 12);
        check("data_en_mask", mask, 32'h0000_001C);
        check("data_stable", {31'h0, ok}, 32'h1);
        check("data_io_setup", io_s, 32'h8000_0241);
        check("data_io_pulse", io_p, 32'h8000_0641);
        @(negedge clk);
        check("idle_keeps_last", io_lcd, 32'h8000_0241);

        // ---- command latency table ----
        foreach (vecs[i]) begin
            write_measure(vecs[i].rs, vecs[i].d, lat, mask, ok, io_p, io_s);
            check($sformatf("cmd_lat_%0d_%h", vecs[i].rs, vecs[i].d), lat, vecs[i].lat);
            check($sformatf("cmd_pulse_%0d_%h", vecs[i].rs, vecs[i].d), mask, 32'h0000_001C);
            check($sformatf("cmd_stable_%0d_%h", vecs[i].rs, vecs[i].d), {31'h0, ok}, 32'h1);
        end

        // ---- req_vld held: accepts at +0, +13, +26 only ----
        @(negedge clk);
        base      = cyc;
        pulse_cnt = 0;
        exp_q.push_back(8'h55); exp_cyc.push_back(base + 3);
        exp_q.push_back(8'h55); exp_cyc.push_back(base + 16);
        exp_q.push_back(8'h55); exp_cyc.push_back(base + 29);
        sb_on    = 1'b1;
        req_vld  = 1'b1;
        req_rs   = 1'b1;
        req_data = 8'h55;
        ok       = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (lcd_data !== 8'h55 || lcd_rs !== 1'b1) ok = 1'b0;
            if (k == 4) req_data = 8'hAA;
            if (k == 8) req_data = 8'h55;
            if (k == 36) req_vld = 1'b0;
        end
        sb_on = 1'b0;
        check("held_pulses", pulse_cnt, 3);
        check("held_data_stable", {31'h0, ok}, 32'h1);
        check("held_sb_left", exp_q.size(), 32'h0);
        check("held_rdy_end", {31'h0, req_rdy}, 32'h1);

        // ---- reset during PULSE ----
        @(negedge clk);
        req_vld  = 1'b1;
        req_rs   = 1'b1;
        req_data = 8'h33;
        @(negedge clk);
        req_vld = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (lcd_en) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstp_en_reached", {31'h0, seen}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rstp_en_low", {31'h0, lcd_en}, 32'h0);
        check("rstp_io", io_lcd, 32'h8000_0000);
        rst       = 1'b0;
        pulse_cnt = 0;
`ifdef LCD_INIT_EN
        check("rstp_rdy", {31'h0, req_rdy}, 32'h0);
        repeat (80) @(negedge clk);
        check("rstp_pulses", pulse_cnt, 4);
`else
        check("rstp_rdy", {31'h0, req_rdy}, 32'h1);
        repeat (80) @(negedge clk);
        check("rstp_pulses", pulse_cnt, 0);
`endif
        check("rstp_rdy_end", {31'h0, req_rdy}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
